// File: rtl/sum_batch_accumulator.sv
// ---------------------------------------------------------------------------
// sum_batch_accumulator
//
// Purpose:
//   Sits behind the registered adder stage and sums every N consecutive
//   results into a wider running total. Each completed batch total is
//   presented on a valid/ready output port through a one-entry output
//   register. The adder cannot be stalled, so every input beat is accepted.
//   Batch overflow is flagged alongside the total. A completed batch that
//   cannot be stored because the output register is still occupied is
//   discarded, and the sticky drop_err flag records the loss.
//
// Parameters:
//   W      input data width (matches the adder result width)
//   N      results per batch, 2..255
//   ACC_W  accumulator / output width, W..W+8
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   result strobe from the adder
//   in_data    unsigned result value from the adder
//   clear      synchronous abort: empties the accumulator and the output
//              register, and clears drop_err
//   out_valid  out_sum/out_ovf hold a completed batch
//   out_ready  consumer accepts the batch when high together with out_valid
//   out_sum    batch total
//   out_ovf    batch total exceeded 2^ACC_W-1 during accumulation
//   busy       accumulator holds part of an incomplete batch
//   drop_err   sticky: a completed batch was discarded
//
// Build option:
//   SUM_ACC_SATURATE_EN  when defined, the accumulator clamps at 2^ACC_W-1
//                        on overflow. When undefined, it wraps modulo
//                        2^ACC_W. out_ovf behaves the same in both builds.
// ---------------------------------------------------------------------------
module sum_batch_accumulator #(
  parameter int W     = 10,
  parameter int N     = 4,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic             drop_err
);

  // The counter only ever holds 0..N-1. The beat that would bring it to N
  // completes the batch and returns it to 0 instead.
  localparam int                CNT_W    = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

  // Accumulator states
  localparam logic [0:0] S_EMPTY   = 1'b0;
  localparam logic [0:0] S_ACCUM   = 1'b1;

  // Output register states
  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  logic [0:0]       acc_state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             batch_ovf;

  logic [0:0]       out_state;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic             drop_q;

  logic             accept;
  logic             transfer;
  logic             complete;
  logic             load;
  logic             discard;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic             ovf_add;

  // Add the new beat to the running total. The extra top bit of sum_ext
  // catches the carry that defines a batch overflow. Once the saturating
  // build has clamped at ACC_MAX, any further non-zero beat carries again,
  // so the value stays clamped without extra state.
  always_comb begin
    in_ext  = ACC_W'(in_data);
    sum_ext = {1'b0, acc} + {1'b0, in_ext};
    carry   = sum_ext[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    acc_add = carry ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
    ovf_add = batch_ovf | carry;
  end

  // Handshake and completion decisions. clear overrides both the input beat
  // and any pending output transfer on the same edge. A completing batch
  // may reuse the output slot that is being drained on the same edge.
  // Otherwise a full slot forces the new batch to be dropped.
  always_comb begin
    accept   = in_valid & ~clear;
    transfer = (out_state == OUT_FULL) & out_ready & ~clear;
    complete = accept & (cnt == LAST_CNT);
    load     = complete & ((out_state == OUT_EMPTY) | transfer);
    discard  = complete & ~load;
  end

  // Accumulator: collects beats until the Nth one. On the completion edge
  // the total moves on (or is dropped), and the accumulator restarts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state <= S_EMPTY;
      cnt       <= '0;
      acc       <= '0;
      batch_ovf <= 1'b0;
    end else if (clear) begin
      acc_state <= S_EMPTY;
      cnt       <= '0;
      acc       <= '0;
      batch_ovf <= 1'b0;
    end else if (accept) begin
      if (complete) begin
        acc_state <= S_EMPTY;
        cnt       <= '0;
        acc       <= '0;
        batch_ovf <= 1'b0;
      end else begin
        acc_state <= S_ACCUM;
        cnt       <= cnt + CNT_W'(1);
        acc       <= acc_add;
        batch_ovf <= ovf_add;
      end
    end
  end

  // One-entry output register with sticky drop reporting. The held batch
  // stays unchanged while it waits for out_ready, even if later batches
  // complete and are discarded in the meantime.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_EMPTY;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else if (clear) begin
      out_state <= OUT_EMPTY;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (load) begin
        out_state <= OUT_FULL;
        out_sum_q <= acc_add;
        out_ovf_q <= ovf_add;
      end else if (transfer) begin
        out_state <= OUT_EMPTY;
      end
      if (discard) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign out_valid = (out_state == OUT_FULL);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (acc_state == S_ACCUM);
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_sum_batch_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_batch_accumulator
//
// Drives two instances of sum_batch_accumulator with the same stimulus:
//   dut_a  default configuration (W=10, N=4, ACC_W=14)
//   dut_b  narrow accumulator (W=10, N=4, ACC_W=11), so overflow is reachable
//
// The reference model tracks each batch as a plain integer total. It derives
// the expected out_sum and out_ovf from that total using the overflow rule of
// each accumulator width. The directed scenarios run first, followed by
// randomized traffic.
// ---------------------------------------------------------------------------
module tb_sum_batch_accumulator;

  localparam int W       = 10;
  localparam int N       = 4;
  localparam int ACC_W_A = 14;
  localparam int ACC_W_B = 11;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [W-1:0]       in_data;
  logic               clear;
  logic               out_ready;

  logic               out_valid_a, out_ovf_a, busy_a, drop_err_a;
  logic [ACC_W_A-1:0] out_sum_a;
  logic               out_valid_b, out_ovf_b, busy_b, drop_err_b;
  logic [ACC_W_B-1:0] out_sum_b;

  int tests_run;
  int fail_count;

  // Reference model state
  int m_cnt;
  int m_total;
  bit m_out_valid;
  int m_out_total;
  bit m_drop;

  sum_batch_accumulator #(.W(W), .N(N), .ACC_W(ACC_W_A)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_sum   (out_sum_a),
    .out_ovf   (out_ovf_a),
    .busy      (busy_a),
    .drop_err  (drop_err_a)
  );

  sum_batch_accumulator #(.W(W), .N(N), .ACC_W(ACC_W_B)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_ovf   (out_ovf_b),
    .busy      (busy_b),
    .drop_err  (drop_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected batch total for a given accumulator width
  function automatic int expSum(input int total, input int accw);
    int maxv;
    maxv = (1 << accw) - 1;
`ifdef SUM_ACC_SATURATE_EN
    return (total > maxv) ? maxv : total;
`else
    return total % (1 << accw);
`endif
  endfunction

  function automatic int expOvf(input int total, input int accw);
    return (total > ((1 << accw) - 1)) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Compare both DUTs against the model
  task automatic checkAll();
    checkOutput("out_valid_a", int'(out_valid_a), int'(m_out_valid));
    checkOutput("out_valid_b", int'(out_valid_b), int'(m_out_valid));
    checkOutput("busy_a", int'(busy_a), (m_cnt != 0) ? 1 : 0);
    checkOutput("busy_b", int'(busy_b), (m_cnt != 0) ? 1 : 0);
    checkOutput("drop_err_a", int'(drop_err_a), int'(m_drop));
    checkOutput("drop_err_b", int'(drop_err_b), int'(m_drop));
    if (m_out_valid) begin
      checkOutput("out_sum_a", int'(out_sum_a), expSum(m_out_total, ACC_W_A));
      checkOutput("out_sum_b", int'(out_sum_b), expSum(m_out_total, ACC_W_B));
      checkOutput("out_ovf_a", int'(out_ovf_a), expOvf(m_out_total, ACC_W_A));
      checkOutput("out_ovf_b", int'(out_ovf_b), expOvf(m_out_total, ACC_W_B));
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelStep(input bit v, input int d, input bit clr, input bit rdy);
    if (clr) begin
      m_cnt       = 0;
      m_total     = 0;
      m_out_valid = 0;
      m_drop      = 0;
    end else begin
      if (m_out_valid && rdy) m_out_valid = 0;
      if (v) begin
        m_total += d;
        m_cnt++;
        if (m_cnt == N) begin
          if (!m_out_valid) begin
            m_out_valid = 1;
            m_out_total = m_total;
          end else begin
            m_drop = 1;
          end
          m_cnt   = 0;
          m_total = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit clr, input bit rdy);
    in_valid  = v;
    in_data   = W'(d);
    clear     = clr;
    out_ready = rdy;
    modelStep(v, d, clr, rdy);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asynchronous reset pulse placed between clock edges. The outputs are
  // checked while rst is still high.
  task automatic doReset();
    rst = 1'b1;
    #2;
    m_cnt       = 0;
    m_total     = 0;
    m_out_valid = 0;
    m_out_total = 0;
    m_drop      = 0;
    checkOutput("rst_out_sum_a", int'(out_sum_a), 0);
    checkOutput("rst_out_sum_b", int'(out_sum_b), 0);
    checkOutput("rst_out_ovf_a", int'(out_ovf_a), 0);
    checkOutput("rst_out_ovf_b", int'(out_ovf_b), 0);
    checkAll();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    in_valid   = 1'b0;
    in_data    = '0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    rst        = 1'b0;
    #1;
    doReset();

    // Basic batch
    for (int i = 1; i <= 4; i++) applyStimulus(1, 100 * i, 0, 1);
    checkOutput("basic_sum", int'(out_sum_a), 1000);
    checkOutput("basic_busy", int'(busy_a), 0);
    applyStimulus(0, 0, 0, 1);

    // Back-to-back batches with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, i, 0, 1);
      if (i == 4) checkOutput("b2b_sum1", int'(out_sum_a), 10);
      if (i == 8) checkOutput("b2b_sum2", int'(out_sum_a), 26);
    end
    applyStimulus(0, 0, 0, 1);

    // Backpressure and drop
    for (int i = 1; i <= 12; i++) applyStimulus(1, i, 0, 0);
    checkOutput("bp_held_sum", int'(out_sum_a), 10);
    checkOutput("bp_drop", int'(drop_err_a), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_after_xfer_valid", int'(out_valid_a), 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("bp_drop_cleared", int'(drop_err_a), 0);

    // Overflow on the narrow instance
    for (int i = 0; i < 4; i++) applyStimulus(1, 1023, 0, 1);
    checkOutput("ovf_flag_b", int'(out_ovf_b), 1);
`ifdef SUM_ACC_SATURATE_EN
    checkOutput("ovf_sum_b", int'(out_sum_b), 2047);
`else
    checkOutput("ovf_sum_b", int'(out_sum_b), 2044);
`endif
    checkOutput("ovf_sum_a", int'(out_sum_a), 4092);
    applyStimulus(0, 0, 0, 1);

    // Reset in the middle of a batch
    applyStimulus(1, 5, 0, 1);
    applyStimulus(1, 6, 0, 1);
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 1);
    checkOutput("rst_batch_sum", int'(out_sum_a), 10);
    applyStimulus(0, 0, 0, 1);

    // clear colliding with an input beat
    for (int i = 0; i < 3; i++) applyStimulus(1, 7, 0, 1);
    applyStimulus(1, 9, 1, 1);
    checkOutput("clr_busy", int'(busy_a), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 0, 1);
    checkOutput("clr_sum", int'(out_sum_a), 8);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit v, clr, rdy;
      int d;
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 2) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 1023);
      if ($urandom_range(0, 199) == 0) doReset();
      applyStimulus(v, d, clr, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/sum_batch_accumulator.md
# sum_batch_accumulator

Downstream consumer of the registered adder stage: samples every `valid`/`y` result it produces, accumulates N consecutive results into a wider running total, and presents each completed batch total on a valid/ready output port. The adder has no backpressure, so this block accepts every input beat unconditionally. A one-entry output register decouples accumulation from the output handshake. Batch-level overflow is flagged, and lost batches are reported sticky.

## Interface
- `W`, 10, input data width (matches adder `y`)
- `N`, 4, results per batch; legal range 2..255
- `ACC_W`, 14, accumulator/output width; legal range W..W+8
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, asynchronous, active-high
- `in_valid`  input  1  result strobe, wired to the adder's `valid`
- `in_data`  input  W  result value, wired to the adder's `y`, unsigned
- `clear`  input  1  synchronous abort: empty the accumulator and output register, clear `drop_err`
- `out_valid`  output  1  `out_sum`/`out_ovf` hold a completed batch
- `out_ready`  input  1  consumer accepts the batch when high with `out_valid`
- `out_sum`  output  ACC_W  batch total
- `out_ovf`  output  1  batch exceeded 2^ACC_W-1 during accumulation
- `busy`  output  1  accumulator holds at least 1 sample of an incomplete batch
- `drop_err`  output  1  sticky: a completed batch was discarded

## Operation
- The accumulator has two states, EMPTY (`cnt`=0) and ACCUM (1 ≤ `cnt` ≤ N-1). `busy` = (state==ACCUM).
- An input beat is accepted on any rising edge with `in_valid`=1 and `clear`=0. No beat is ever refused.
- Each accepted beat adds the zero-extended `in_data` to `acc`.
- A beat that brings `cnt` to N completes the batch:
  - The final total and the batch overflow flag go to the output register.
  - `acc`, `cnt` and the overflow flag return to 0 in the same edge, so the state returns to EMPTY.
- Arithmetic is unsigned. If the add carries out of ACC_W bits on any beat, the batch overflow flag sets. Overflow value handling is set by the macro under Configuration.
- Output register states, OUT_EMPTY and OUT_FULL:
  - A transfer happens on a rising edge with `out_valid`=1 and `out_ready`=1.
  - On a completion edge, the output register loads if it is OUT_EMPTY, or if it is OUT_FULL and a transfer happens on the same edge. It stays OUT_FULL; there is no bubble and no loss.
  - On a completion edge with OUT_FULL and no transfer, the new batch is discarded, the held batch is kept unchanged, and `drop_err` sets.
- `out_sum` and `out_ovf` are stable while `out_valid`=1 and `out_ready`=0.
- `clear` has priority over everything:
  - It zeroes `acc`, `cnt` and the overflow flag, and empties the output register (`out_valid`→0).
  - It clears `drop_err`.
  - An `in_valid` beat on the same edge is discarded.
  - A pending handshake on the same edge counts as no transfer.
- `drop_err` clears only by `rst` or `clear`.

## Timing
- Reset values: `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0, `drop_err`=0. Internal `acc`=0, `cnt`=0.
- `rst` asserted mid-batch or mid-handshake: all state clears immediately (asynchronous) and the partial batch is lost. The first beat after `rst` falls starts a new batch.
- Latency: `out_valid` rises on the edge that accepts the Nth beat, so it is visible 1 cycle after that beat's `in_valid` was sampled.
- Throughput: 1 beat per cycle sustained. With `out_ready` held high, back-to-back batches produce `out_valid` pulses every N cycles.
- `busy` rises on the edge that accepts the first beat and falls on the completion edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SUM_ACC_SATURATE_EN` defined: on overflow, `acc` clamps to 2^ACC_W-1 and stays clamped for the rest of the batch. `out_ovf` still reports the overflow.
- Not defined: `acc` wraps modulo 2^ACC_W. `out_ovf` reports the overflow.
- In both builds, `out_ovf` is identical; only `out_sum` differs.

## Test plan
- Basic batch (defaults): beats 100, 200, 300, 400 on consecutive cycles, `out_ready`=1 → `out_valid` high 1 cycle after the 4th beat, `out_sum`=1000, `out_ovf`=0, `busy` falls on that same edge.
- Back-to-back with `out_ready`=1: 8 consecutive beats 1..8 → two single-cycle `out_valid` pulses, 4 cycles apart, `out_sum`=10 then 26, `drop_err`=0.
- Backpressure and drop: `out_ready`=0, beats 1..12 → `out_valid` stays high with `out_sum`=10; batches 26 and 42 are dropped; `drop_err`=1. Then raise `out_ready` → one transfer, `out_valid`→0, `drop_err` stays 1 until `clear`.
- Overflow (ACC_W=11, N=4): four beats of 1023 → `out_ovf`=1. `out_sum`=2044 without the macro; `out_sum`=2047 with `SUM_ACC_SATURATE_EN`.
- Reset mid-batch:
  - 2 beats (5, 6), then a 1-cycle `rst` pulse → all outputs 0, `busy`=0.
  - Then beats 1, 2, 3, 4 → `out_sum`=10, with no contribution from 5 or 6.
- Clear collision: 3 beats accepted, then `clear` and `in_valid` (value 9) on the same edge → beat discarded, `busy`=0. The next 4 beats (2 each) → `out_sum`=8.
